gray_seq: RTL and testbench

Sequencer for a 4-bit (parameterisable) binary-to-Gray converter. It steps a binary count from 0 up to a programmed limit and drives the count into the converter. Each binary/Gray pair is presented on a valid/ready output stream, one beat per count. The block sits between a control master (start/limit) and a Gray-code consumer such as a display, encoder stimulus or CDC pointer checker.

---
 rtl/gray_pkg.sv | 13 +
 rtl/bin2gray_conv.sv | 14 +
 rtl/gray_seq.sv | 111 +++++++++++
 tb/tb_gray_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// gray_pkg: shared types and constants for the Gray-code sequencer.
// Holds the FSM state encoding and the default count width.
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bin2gray_conv.sv
// bin2gray_conv: combinational binary-to-Gray converter.
// The MSB passes through; every other bit is XORed with its upper neighbour.
module bin2gray_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_seq.sv
// gray_seq: steps a count 0..limit and streams each binary/Gray pair.
// Define GRAY_SEQ_DOWN_EN to add the dir port and down-count runs.
module gray_seq
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
`ifdef GRAY_SEQ_DOWN_EN
  input  logic             dir,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bin,
  output logic [WIDTH-1:0] out_gray,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             last;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] cnt_ld;

`ifdef GRAY_SEQ_DOWN_EN
  logic dir_q, dir_d;

  // Direction picks the start value, the step and the terminal count.
  always_comb begin
    cnt_ld  = dir ? limit : '0;
    last    = dir_q ? (cnt_q == '0) : (cnt_q == lim_q);
    cnt_nxt = dir_q ? (cnt_q - ONE) : (cnt_q + ONE);
  end

  // Direction is captured with start and held for the whole run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_q <= 1'b0;
    else        dir_q <= dir_d;
  end
`else
  // Up-only: runs start at 0 and stop at the latched limit.
  always_comb begin
    cnt_ld  = '0;
    last    = (cnt_q == lim_q);
    cnt_nxt = cnt_q + ONE;
  end
`endif

  // State, count and limit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
    end
  end

  // Next state: start only in IDLE, advance on each accepted beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
`ifdef GRAY_SEQ_DOWN_EN
    dir_d   = dir_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          lim_d   = limit;
          cnt_d   = cnt_ld;
`ifdef GRAY_SEQ_DOWN_EN
          dir_d   = dir;
`endif
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last) state_d = DONE;
          else      cnt_d   = cnt_nxt;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_bin   = cnt_q;

  bin2gray_conv #(
    .WIDTH(WIDTH)
  ) u_conv (
    .bin (cnt_q),
    .gray(out_gray)
  );

endmodule

// File: tb/tb_gray_seq.sv
// tb_gray_seq: directed checks of the Gray-code sequencer.
// Covers up runs, backpressure, limit 0, async reset and down runs.
module tb_gray_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] limit;
  logic       dir;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_bin;
  logic [3:0] out_gray;
  logic       busy;
  logic       done;

  int errs;
  int checks;

  logic [3:0] g_tab [16];

  gray_seq #(
    .WIDTH(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .limit    (limit),
`ifdef GRAY_SEQ_DOWN_EN
    .dir      (dir),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bin  (out_bin),
    .out_gray (out_gray),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic chk_beat(input string tag, input int b);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_bin"}, 32'(out_bin), 32'(b));
    chk({tag, "_gray"}, 32'(out_gray), 32'(g_tab[b]));
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    g_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
              4'b0110, 4'b0111, 4'b0101, 4'b0100,
              4'b1100, 4'b1101, 4'b1111, 4'b1110,
              4'b1010, 4'b1011, 4'b1001, 4'b1000};
    rst_n     = 1'b0;
    start     = 1'b0;
    limit     = 4'd0;
    dir       = 1'b0;
    out_ready = 1'b0;

    // Reset state
    step();
    step();
    chk_idle("rst");
    chk("rst_bin", 32'(out_bin), 0);
    chk("rst_gray", 32'(out_gray), 0);
    rst_n = 1'b1;
    step();
    chk_idle("idle0");

    // Run 1: limit 8, ready high, limit changed mid-run
    limit     = 4'd8;
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      chk_beat($sformatf("r1_b%0d", k), k);
      if (k == 3) limit = 4'd2;
      step();
    end
    chk("r1_done", 32'(done), 1);
    chk("r1_dvalid", 32'(out_valid), 0);
    chk("r1_dbusy", 32'(busy), 1);
    step();
    chk_idle("r1_end");

    // Run 2: limit 15, ready toggling
    limit = 4'd15;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      out_ready = 1'b0;
      chk_beat($sformatf("r2_b%0d", k), k);
      step();
      chk_beat($sformatf("r2_hold%0d", k), k);
      out_ready = 1'b1;
      step();
    end
    chk("r2_done", 32'(done), 1);
    chk("r2_dvalid", 32'(out_valid), 0);
    chk("r2_nowrap", 32'(out_bin), 15);
    step();
    chk_idle("r2_end");

    // Run 3: limit 0, start held through EMIT and DONE
    limit = 4'd0;
    start = 1'b1;
    step();
    chk_beat("r3_b0", 0);
    step();
    chk("r3_done", 32'(done), 1);
    chk("r3_dvalid", 32'(out_valid), 0);
    step();
    start = 1'b0;
    chk_idle("r3_idle");
    step();
    chk_idle("r3_nomore");

    // Run 4: async reset at bin 5, then restart
    limit = 4'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk_beat("r4_b5", 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("r4_rst");
    chk("r4_rbin", 32'(out_bin), 0);
    chk("r4_rgray", 32'(out_gray), 0);
    step();
    chk("r4_nodone", 32'(done), 0);
    rst_n = 1'b1;
    step();
    chk_idle("r4_post");
    limit = 4'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      chk_beat($sformatf("r4_re%0d", k), k);
      step();
    end
    chk("r4_redone", 32'(done), 1);
    step();
    chk_idle("r4_end");

`ifdef GRAY_SEQ_DOWN_EN
    // Run 5: down count from 4
    limit = 4'd4;
    dir   = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    dir   = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      chk_beat($sformatf("r5_b%0d", k), k);
      step();
    end
    chk("r5_done", 32'(done), 1);
    step();
    chk_idle("r5_end");
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
